fmdll_cfg_sequencer: RTL

Controller on the clk_ext side that drives the FMDLL configuration inputs (M, N) and the DLL reset, then decides whether the DLL has settled. A host requests one ratio from a fixed table of supported N/M pairs. The block applies the pair, holds the DLL in reset, waits a settle window, then watches the DLL's Sel output. It reports either locked or timeout through a one-cycle acknowledge.

---
 rtl/fmdll_cfg_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/fmdll_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// fmdll_cfg_sequencer
//
// Purpose:
//   Runs on clk_ext and drives the FMDLL configuration (M, N) and its reset.
//   A host request selects one N/M pair from a fixed ratio table. The block
//   applies the pair, holds the DLL in reset, waits a settle window, then
//   watches the synchronized Sel output. The sequence ends with a one-cycle
//   ack that reports either lock or timeout.
//
// Ports:
//   clk_ext    in   1  reference clock, sole clock of the block
//   rst        in   1  asynchronous, active-high reset
//   req        in   1  start request, sampled on rising clk_ext
//   ratio_idx  in   3  ratio table index, captured with req
//   ack        out  1  one-cycle completion pulse (first DONE cycle)
//   M          out  2  DLL divider setting
//   N          out  4  DLL multiplier setting
//   dll_rst_n  out  1  active-low reset to the FMDLL
//   sel_in     in   2  FMDLL Sel, asynchronous to clk_ext
//   busy       out  1  high from request accept until ack
//   locked     out  1  last sequence ended in lock
//   err        out  2  00 none, 01 invalid index, 10 timeout
// -----------------------------------------------------------------------------
module fmdll_cfg_sequencer #(
  parameter int RST_CYC    = 4,
  parameter int SETTLE_CYC = 16,
  parameter int LOCK_CYC   = 32,
  parameter int TMO_CYC    = 1024
) (
  input  logic       clk_ext,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] ratio_idx,
  output logic       ack,
  output logic [1:0] M,
  output logic [3:0] N,
  output logic       dll_rst_n,
  input  logic [1:0] sel_in,
  output logic       busy,
  output logic       locked,
  output logic [1:0] err
);

  // One counter width covers every window; sized from the largest parameter.
  localparam int MAX_A   = (RST_CYC  > SETTLE_CYC) ? RST_CYC  : SETTLE_CYC;
  localparam int MAX_B   = (LOCK_CYC > TMO_CYC)    ? LOCK_CYC : TMO_CYC;
  localparam int MAX_CYC = (MAX_A    > MAX_B)      ? MAX_A    : MAX_B;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] ONE         = CW'(1);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_IDX  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRST,
    S_SETTLE,
    S_WATCH,
    S_DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;       // DRST and SETTLE window counter
  logic [CW-1:0] stab, stab_d;     // consecutive unchanged-Sel compares
  logic [CW-1:0] tmo, tmo_d;       // cycles spent in WATCH
  logic          bad_idx, bad_d;   // captured request used an invalid index
  logic [1:0]    m_d;
  logic [3:0]    n_d;
  logic          rstn_d, ack_d, busy_d, locked_d;
  logic [1:0]    err_d;

  // Sel synchronizer plus one history stage for the stability compare.
  logic [1:0] sel_s1, sel_sync, sel_prev;
  logic       sel_same;

  // Ratio table lookup on the live index; only used on the accept cycle.
  logic       tbl_ok;
  logic [1:0] tbl_m;
  logic [3:0] tbl_n;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    tbl_ok = 1'b1;
    tbl_m  = 2'd2;
    tbl_n  = 4'd4;
    case (ratio_idx)
      3'd0:    begin tbl_n = 4'd4;  tbl_m = 2'd2; end
      3'd1:    begin tbl_n = 4'd8;  tbl_m = 2'd2; end
      3'd2:    begin tbl_n = 4'd10; tbl_m = 2'd2; end
      3'd3:    begin tbl_n = 4'd4;  tbl_m = 2'd3; end
      3'd4:    begin tbl_n = 4'd5;  tbl_m = 2'd3; end
      3'd5:    begin tbl_n = 4'd10; tbl_m = 2'd3; end
      default: tbl_ok = 1'b0;
    endcase
  end

  assign sel_same = (sel_sync == sel_prev);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    stab_d   = stab;
    tmo_d    = tmo;
    bad_d    = bad_idx;
    m_d      = M;
    n_d      = N;
    rstn_d   = dll_rst_n;
    ack_d    = 1'b0;
    busy_d   = busy;
    locked_d = locked;
    err_d    = err;

    case (state)
      S_IDLE, S_DONE: begin
        if (req) begin
          busy_d   = 1'b1;
          locked_d = 1'b0;
          err_d    = ERR_NONE;
          cnt_d    = '0;
          bad_d    = ~tbl_ok;
          state_d  = S_DRST;
          // An invalid index leaves M, N and the DLL reset untouched; it
          // passes through DRST for one cycle only to give busy its cycle.
          if (tbl_ok) begin
            m_d    = tbl_m;
            n_d    = tbl_n;
            rstn_d = 1'b0;
          end
        end
      end

      S_DRST: begin
        if (bad_idx) begin
          err_d   = ERR_IDX;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else if (cnt == RST_LAST) begin
          rstn_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt + ONE;
        end
      end

      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          stab_d  = '0;
          tmo_d   = '0;
          state_d = S_WATCH;
        end else begin
          cnt_d = cnt + ONE;
        end
      end

      S_WATCH: begin
        tmo_d  = tmo + ONE;
        stab_d = sel_same ? (stab + ONE) : '0;
        // Lock needs LOCK_CYC consecutive unchanged compares: LOCK_CYC-1
        // already counted plus this one. Checked first so lock beats timeout.
        if (sel_same && (stab == LOCK_LAST)) begin
          locked_d = 1'b1;
          ack_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end else if (tmo == TMO_LAST) begin
          err_d    = ERR_TMO;
          locked_d = 1'b0;
          ack_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      stab      <= '0;
      tmo       <= '0;
      bad_idx   <= 1'b0;
      M         <= 2'd2;
      N         <= 4'd4;
      dll_rst_n <= 1'b0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      locked    <= 1'b0;
      err       <= ERR_NONE;
      sel_s1    <= 2'b00;
      sel_sync  <= 2'b00;
      sel_prev  <= 2'b00;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      stab      <= stab_d;
      tmo       <= tmo_d;
      bad_idx   <= bad_d;
      M         <= m_d;
      N         <= n_d;
      dll_rst_n <= rstn_d;
      ack       <= ack_d;
      busy      <= busy_d;
      locked    <= locked_d;
      err       <= err_d;
      sel_s1    <= sel_in;
      sel_sync  <= sel_s1;
      sel_prev  <= sel_sync;
    end
  end

endmodule
